move_seq_ctl: RTL and testbench
===============================

// Module: move_seq_ctl
// PURPOSE
//  Owns the 8x8 chess board register file and sequences a move.
//  - Accepts pick/place requests and a square index from the mouse-side controller.
//  - Latches the source square, commits the two board writes, then toggles the turn.
//  - board[][] feeds the renderer and the move generator; dst_legal comes back from the move generator.
// PARAMETERS
//  PROMOTE_TYPE  3'd5  piece type written when a pawn reaches the far rank (5=queen)
//  WHITE_FIRST   1     1: white moves first after reset; 0: black moves first
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  pick_req     in   1        1-cycle pulse: select the piece on square
//  place_req    in   1        1-cycle pulse: move the selected piece to square
//  square       in   6        [5:3]=row, [2:0]=col, sampled with a req
//  dst_legal    in   1        move generator verdict for src->square, valid with place_req
//  board        out  4x8x8    board[row][col]; 0=empty, [3]=colour (1=black), [2:0]=type
//  turn         out  1        side to move, 0=white, 1=black
//  sel_valid    out  1        a source square is latched
//  sel_square   out  6        latched source square
//  busy         out  1        write sequence in progress; reqs ignored
//  move_done    out  1        1-cycle pulse when a move is committed
//  captured     out  4        piece removed by the last move (0 if none)
//  reject       out  1        1-cycle pulse: request refused
//  undo_req     in   1        only with MOVE_UNDO_EN: revert the last move
// BEHAVIOUR
//  Reset values
//   - board = standard start position.
//   - Row 0: black R N B Q K B N R. Row 1: black pawns. Rows 6/7: white pawns / back rank.
//   - Types: 1=pawn, 2=knight, 3=bishop, 4=rook, 5=queen, 6=king.
//   - turn = ~WHITE_FIRST; all other outputs = 0; state = IDLE.
//  State IDLE
//   - pick_req on a piece with colour==turn: latch src; sel_valid=1 next cycle; -> SEL.
//   - pick_req on an empty square or an opponent piece: reject pulse; stay in IDLE.
//   - place_req: ignored.
//  State SEL (place_req has priority if pick_req arrives in the same cycle)
//   - place_req, square==src: deselect; sel_valid=0; -> IDLE.
//   - place_req on an own-colour piece: re-latch src = square; stay in SEL.
//   - place_req with dst_legal=1: latch dst; busy=1; -> WR_DST.
//   - place_req with dst_legal=0: reject pulse; stay in SEL.
//   - pick_req alone: behaves as a re-select, same rules as IDLE.
//  State WR_DST
//   - captured <= board[dst].
//   - board[dst] <= moving piece. A pawn landing on row 0 (white) or row 7 (black) is written with type PROMOTE_TYPE.
//   - -> WR_SRC.
//  State WR_SRC
//   - board[src] <= 0; -> TURN.
//  State TURN
//   - turn toggles; move_done=1 for this cycle; sel_valid=0; busy=0 next cycle; -> IDLE.
//  Timing and edge cases
//   - Latency: accepted place_req (cycle N) -> WR_DST N+1, WR_SRC N+2, move_done in N+3.
//   - busy is high in WR_DST, WR_SRC and TURN. Any req during busy is dropped silently (no reject).
//   - Exactly one board cell changes per cycle.
//   - rst mid-sequence: board and all state return to the reset values on the next edge; no partial move persists.
// CONFIGURATION
//  MOVE_UNDO_EN defined
//   - undo_req port exists.
//   - A single-level record {src, dst, original piece, captured, valid} is written in WR_DST.
//   - undo_req in IDLE with the record valid -> UN_DST (board[dst] <= captured) -> UN_SRC (board[src] <= original piece, promotion undone) -> TURN.
//   - On that TURN: turn toggles back, move_done does not pulse, and the record is invalidated.
//   - undo_req in IDLE with no valid record: reject pulse.
//   - undo_req in any state other than IDLE: ignored.
//  MOVE_UNDO_EN undefined
//   - No undo_req port, no record registers, UN_* states absent.
// TESTING
//  1 rst -> board[7][4]=4'h6, board[0][3]=4'hD, board[3][3]=0, turn=0, all flags 0.
//  2 pick 6'o64, place 6'o44 with dst_legal=1 -> busy 3 cycles, move_done at N+3, board[4][4]=1, board[6][4]=0, turn=1.
//  3 turn=0: pick 6'o14 (black pawn) -> reject=1, sel_valid stays 0; pick 6'o30 (empty) -> reject.
//  4 SEL on 6'o64; place 6'o63 (own pawn) -> sel_square=6'o63, no reject; place 6'o63 again -> sel_valid=0, IDLE.
//  5 White pawn on 6'o10, black rook on 6'o01; place 6'o01 with dst_legal=1 -> captured=4'hC, board[0][1]=4'h5.
//  6 MOVE_UNDO_EN: after test 5, undo_req -> board[0][1]=4'hC, board[1][0]=4'h1, turn=0, no move_done; second undo -> reject.
//  7 place_req with dst_legal=0 -> reject pulse, board unchanged; rst asserted during WR_SRC -> start position restored next cycle.

Source files
------------

// File: rtl/move_seq_ctl.sv
// move_seq_ctl: owns the chess board register file and sequences pick/place moves.
// Optional `MOVE_UNDO_EN adds an undo_req port and a single-level move record for reverting the last move.
module move_seq_ctl #(
    parameter logic [2:0] PROMOTE_TYPE = 3'd5,
    parameter bit         WHITE_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pick_req,
    input  logic                  place_req,
    input  logic [5:0]            square,
    input  logic                  dst_legal,
`ifdef MOVE_UNDO_EN
    input  logic                  undo_req,
`endif
    output logic [7:0][7:0][3:0]  board,
    output logic                  turn,
    output logic                  sel_valid,
    output logic [5:0]            sel_square,
    output logic                  busy,
    output logic                  move_done,
    output logic [3:0]            captured,
    output logic                  reject
);
`ifdef MOVE_UNDO_EN
    typedef enum logic [2:0] {IDLE, SEL, WR_DST, WR_SRC, TURN, UN_DST, UN_SRC} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEL, WR_DST, WR_SRC, TURN} state_t;
`endif
    state_t                 state_q, state_d;
    logic [7:0][7:0][3:0]   board_q;
    logic                   turn_q, turn_d, sel_valid_q, sel_valid_d, reject_q, reject_d;
    logic [5:0]             src_q, src_d, dst_q, dst_d, wr_addr;
    logic [3:0]             captured_q, captured_d, wr_data, piece_sq, mover, moved;
    logic                   wr_en, own_sq, promo;
`ifdef MOVE_UNDO_EN
    logic [5:0]             rec_src_q, rec_src_d, rec_dst_q, rec_dst_d;
    logic [3:0]             rec_orig_q, rec_orig_d, rec_cap_q, rec_cap_d;
    logic                   rec_valid_q, rec_valid_d, undoing_q, undoing_d;
`endif

    function automatic logic [7:0][7:0][3:0] start_board();
        logic [7:0][7:0][3:0] b;
        logic [7:0][2:0]      back;
        back = {3'd4, 3'd2, 3'd3, 3'd6, 3'd5, 3'd3, 3'd2, 3'd4};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {1'b1, back[c]};
            b[1][c] = 4'h9;
            b[6][c] = 4'h1;
            b[7][c] = {1'b0, back[c]};
        end
        return b;
    endfunction

    assign piece_sq = board_q[square[5:3]][square[2:0]];
    assign own_sq   = (piece_sq != 4'h0) && (piece_sq[3] == turn_q);
    assign mover    = board_q[src_q[5:3]][src_q[2:0]];
    assign promo    = (mover[2:0] == 3'd1) && (dst_q[5:3] == (mover[3] ? 3'd7 : 3'd0));
    assign moved    = promo ? {mover[3], PROMOTE_TYPE} : mover;

    // Next-state, request decoding and the single board write port for this cycle
    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        sel_valid_d = sel_valid_q;
        src_d       = src_q;
        dst_d       = dst_q;
        captured_d  = captured_q;
        reject_d    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = dst_q;
        wr_data     = moved;
`ifdef MOVE_UNDO_EN
        rec_src_d   = rec_src_q;
        rec_dst_d   = rec_dst_q;
        rec_orig_d  = rec_orig_q;
        rec_cap_d   = rec_cap_q;
        rec_valid_d = rec_valid_q;
        undoing_d   = undoing_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_req) begin
                    if (own_sq) begin
                        src_d       = square;
                        sel_valid_d = 1'b1;
                        state_d     = SEL;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
`ifdef MOVE_UNDO_EN
                else if (undo_req) begin
                    if (rec_valid_q) begin
                        undoing_d = 1'b1;
                        state_d   = UN_DST;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
`endif
            end
            SEL: begin
                if (place_req) begin
                    if (square == src_q) begin
                        sel_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else if (own_sq) begin
                        src_d = square;
                    end else if (dst_legal) begin
                        dst_d   = square;
                        state_d = WR_DST;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (pick_req) begin
                    if (own_sq) src_d = square;
                    else reject_d = 1'b1;
                end
            end
            WR_DST: begin
                captured_d = board_q[dst_q[5:3]][dst_q[2:0]];
                wr_en      = 1'b1;
                state_d    = WR_SRC;
`ifdef MOVE_UNDO_EN
                rec_src_d   = src_q;
                rec_dst_d   = dst_q;
                rec_orig_d  = mover;
                rec_cap_d   = board_q[dst_q[5:3]][dst_q[2:0]];
                rec_valid_d = 1'b1;
`endif
            end
            WR_SRC: begin
                wr_en   = 1'b1;
                wr_addr = src_q;
                wr_data = 4'h0;
                state_d = TURN;
            end
            TURN: begin
                turn_d      = ~turn_q;
                sel_valid_d = 1'b0;
                state_d     = IDLE;
`ifdef MOVE_UNDO_EN
                if (undoing_q) rec_valid_d = 1'b0;
                undoing_d = 1'b0;
`endif
            end
`ifdef MOVE_UNDO_EN
            UN_DST: begin
                wr_en   = 1'b1;
                wr_addr = rec_dst_q;
                wr_data = rec_cap_q;
                state_d = UN_SRC;
            end
            UN_SRC: begin
                wr_en   = 1'b1;
                wr_addr = rec_src_q;
                wr_data = rec_orig_q;
                state_d = TURN;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, board and flag registers; reset restores the start position outright
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            board_q     <= start_board();
            turn_q      <= ~WHITE_FIRST;
            sel_valid_q <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            captured_q  <= '0;
            reject_q    <= 1'b0;
`ifdef MOVE_UNDO_EN
            rec_src_q   <= '0;
            rec_dst_q   <= '0;
            rec_orig_q  <= '0;
            rec_cap_q   <= '0;
            rec_valid_q <= 1'b0;
            undoing_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            sel_valid_q <= sel_valid_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            captured_q  <= captured_d;
            reject_q    <= reject_d;
            if (wr_en) board_q[wr_addr[5:3]][wr_addr[2:0]] <= wr_data;
`ifdef MOVE_UNDO_EN
            rec_src_q   <= rec_src_d;
            rec_dst_q   <= rec_dst_d;
            rec_orig_q  <= rec_orig_d;
            rec_cap_q   <= rec_cap_d;
            rec_valid_q <= rec_valid_d;
            undoing_q   <= undoing_d;
`endif
        end
    end

    assign board      = board_q;
    assign turn       = turn_q;
    assign sel_valid  = sel_valid_q;
    assign sel_square = src_q;
    assign busy       = (state_q != IDLE) && (state_q != SEL);
    assign captured   = captured_q;
    assign reject     = reject_q;
`ifdef MOVE_UNDO_EN
    assign move_done  = (state_q == TURN) && !undoing_q;
`else
    assign move_done  = (state_q == TURN);
`endif
endmodule

// File: tb/tb_move_seq_ctl.sv
// tb_move_seq_ctl: randomized and directed checks of move_seq_ctl against a move-level board model.
module tb_move_seq_ctl;
    logic clk = 1'b0, rst = 1'b1, pick_req = 1'b0, place_req = 1'b0, dst_legal = 1'b0;
    logic [5:0] square = '0;
`ifdef MOVE_UNDO_EN
    logic undo_req = 1'b0;
`endif
    logic [7:0][7:0][3:0] board;
    logic turn, sel_valid, busy, move_done, reject;
    logic [5:0] sel_square;
    logic [3:0] captured;
    int checks = 0, failures = 0;

    logic [3:0] mb[64];
    logic       mturn, msel, rv;
    logic [5:0] msrc, rsrc, rdst;
    logic [3:0] mcap, rorig, rcap;

    move_seq_ctl dut (
        .clk(clk), .rst(rst), .pick_req(pick_req), .place_req(place_req),
        .square(square), .dst_legal(dst_legal),
`ifdef MOVE_UNDO_EN
        .undo_req(undo_req),
`endif
        .board(board), .turn(turn), .sel_valid(sel_valid), .sel_square(sel_square),
        .busy(busy), .move_done(move_done), .captured(captured), .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mpack();
        logic [255:0] v;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = mb[i];
        return v;
    endfunction

    function automatic logic own(input logic [5:0] sq);
        return (mb[sq] != 4'h0) && (mb[sq][3] == mturn);
    endfunction

    task automatic mreset();
        logic [2:0] back[8] = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        for (int i = 0; i < 64; i++) mb[i] = 4'h0;
        for (int c = 0; c < 8; c++) begin
            mb[c]      = {1'b1, back[c]};
            mb[8 + c]  = 4'h9;
            mb[48 + c] = 4'h1;
            mb[56 + c] = {1'b0, back[c]};
        end
        mturn = 1'b0; msel = 1'b0; mcap = 4'h0; rv = 1'b0; msrc = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_board"}, board, mpack());
        chk({tag, "_turn"}, 256'(turn), 256'(mturn));
        chk({tag, "_sel"}, 256'(sel_valid), 256'(msel));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(move_done), 256'(0));
        chk({tag, "_cap"}, 256'(captured), 256'(mcap));
        if (msel) chk({tag, "_selsq"}, 256'(sel_square), 256'(msrc));
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mreset();
        chk("rst_rej", 256'(reject), 256'(0));
        check_state("rst");
    endtask

    task automatic noise();
        pick_req  = 1'($urandom_range(0, 1));
        place_req = 1'($urandom_range(0, 1));
        dst_legal = 1'b1;
        square    = 6'($urandom_range(0, 63));
    endtask

    task automatic quiet();
        pick_req = 1'b0; place_req = 1'b0; dst_legal = 1'b0;
    endtask

    task automatic do_pick(input logic [5:0] sq);
        logic er;
        @(negedge clk); square = sq; pick_req = 1'b1;
        @(negedge clk); pick_req = 1'b0;
        er = !own(sq);
        if (!er) begin msrc = sq; msel = 1'b1; end
        chk("pick_rej", 256'(reject), 256'(er));
        check_state("pick");
    endtask

    task automatic do_place(input logic [5:0] sq, input logic legal);
        logic er;
        logic [3:0] p, p0, cap;
        logic [5:0] s;
        logic [255:0] pre, mid;
        @(negedge clk); square = sq; place_req = 1'b1; dst_legal = legal;
        @(negedge clk); quiet();
        er = 1'b0;
        if (msel && sq != msrc && !own(sq) && legal) begin
            pre = mpack(); s = msrc; p0 = mb[s]; p = p0; cap = mb[sq];
            if (p[2:0] == 3'd1 && sq[5:3] == (p[3] ? 3'd7 : 3'd0)) p[2:0] = 3'd5;
            mb[sq] = p; mid = mpack(); mb[s] = 4'h0;
            chk("mv1_busy", 256'(busy), 256'(1));
            chk("mv1_done", 256'(move_done), 256'(0));
            chk("mv1_board", board, pre);
            chk("mv1_rej", 256'(reject), 256'(0));
            noise();
            @(negedge clk); quiet();
            chk("mv2_busy", 256'(busy), 256'(1));
            chk("mv2_board", board, mid);
            chk("mv2_cap", 256'(captured), 256'(cap));
            chk("mv2_rej", 256'(reject), 256'(0));
            noise();
            @(negedge clk); quiet();
            chk("mv3_busy", 256'(busy), 256'(1));
            chk("mv3_done", 256'(move_done), 256'(1));
            chk("mv3_board", board, mpack());
            chk("mv3_rej", 256'(reject), 256'(0));
            noise();
            @(negedge clk); quiet();
            mturn = ~mturn; msel = 1'b0; mcap = cap;
            rv = 1'b1; rsrc = s; rdst = sq; rorig = p0; rcap = cap;
            chk("mv4_rej", 256'(reject), 256'(0));
            check_state("mv4");
        end else begin
            if (msel) begin
                if (sq == msrc) msel = 1'b0;
                else if (own(sq)) msrc = sq;
                else er = 1'b1;
            end
            chk("place_rej", 256'(reject), 256'(er));
            check_state("place");
        end
    endtask

`ifdef MOVE_UNDO_EN
    task automatic do_undo();
        logic [255:0] pre, mid;
        @(negedge clk); undo_req = 1'b1;
        @(negedge clk); undo_req = 1'b0;
        if (!msel && rv) begin
            pre = mpack(); mb[rdst] = rcap; mid = mpack(); mb[rsrc] = rorig;
            chk("un1_busy", 256'(busy), 256'(1));
            chk("un1_board", board, pre);
            @(negedge clk);
            chk("un2_board", board, mid);
            @(negedge clk);
            chk("un3_done", 256'(move_done), 256'(0));
            chk("un3_board", board, mpack());
            @(negedge clk);
            mturn = ~mturn; rv = 1'b0;
            chk("un4_rej", 256'(reject), 256'(0));
            check_state("un4");
        end else begin
            chk("undo_rej", 256'(reject), 256'(!msel));
            check_state("undo");
        end
    endtask
`endif

    initial begin
        logic [5:0] q[$];
        logic [5:0] sq;
        int r;
        mreset();
        repeat (3) @(negedge clk);
        do_reset();
        chk("t1_k", 256'(board[7][4]), 256'(4'h6));
        chk("t1_q", 256'(board[0][3]), 256'(4'hD));
        chk("t1_e", 256'(board[3][3]), 256'(4'h0));
        do_pick(6'o14);
        chk("t3_sel", 256'(sel_valid), 256'(0));
        do_pick(6'o30);
        do_pick(6'o64);
        do_place(6'o63, 1'b1);
        chk("t4_selsq", 256'(sel_square), 256'(6'o63));
        do_place(6'o63, 1'b1);
        do_pick(6'o64);
        do_place(6'o44, 1'b0);
        do_place(6'o44, 1'b1);
        chk("t2_44", 256'(board[4][4]), 256'(4'h1));
        chk("t2_64", 256'(board[6][4]), 256'(4'h0));
        chk("t2_turn", 256'(turn), 256'(1));
        do_reset();
        do_pick(6'o60); do_place(6'o10, 1'b1);
        do_pick(6'o01); do_place(6'o22, 1'b1);
        do_pick(6'o63); do_place(6'o43, 1'b1);
        do_pick(6'o00); do_place(6'o01, 1'b1);
        do_pick(6'o10); do_place(6'o01, 1'b1);
        chk("t5_cap", 256'(captured), 256'(4'hC));
        chk("t5_sq", 256'(board[0][1]), 256'(4'h5));
`ifdef MOVE_UNDO_EN
        do_undo();
        chk("t6_01", 256'(board[0][1]), 256'(4'hC));
        chk("t6_10", 256'(board[1][0]), 256'(4'h1));
        chk("t6_turn", 256'(turn), 256'(0));
        do_undo();
`endif
        do_pick(6'o64);
        @(negedge clk); square = 6'o44; place_req = 1'b1; dst_legal = 1'b1;
        @(negedge clk); quiet();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mreset();
        check_state("t7_rst");
        for (int it = 0; it < 400; it++) begin
            if (it % 100 == 99) do_reset();
            r = $urandom_range(0, 9);
            if (r < 4) begin
                q.delete();
                for (int i = 0; i < 64; i++) if (own(6'(i))) q.push_back(6'(i));
                sq = ($urandom_range(0, 9) < 7 && q.size() > 0) ? q[$urandom_range(0, q.size() - 1)] : 6'($urandom_range(0, 63));
                do_pick(sq);
            end
`ifdef MOVE_UNDO_EN
            else if (r == 9) do_undo();
`endif
            else begin
                sq = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) sq[5:3] = mturn ? 3'd7 : 3'd0;
                do_place(sq, $urandom_range(0, 3) != 0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
